// File: rtl/y_pkg.sv
// rtl/y_pkg.sv - shared Y-path constants: line/tag widths, memory address width, decoder constants
package y_pkg;

  localparam int LINE_W = 256;
  localparam int TAG_W  = 16;
  localparam int ADDR_W = 11;

  // Y-path address decoder constants, kept beside the line geometry they describe
  localparam logic [ADDR_W-1:0] Y_BASE_ADDR   = 11'h400;
  localparam logic [ADDR_W-1:0] Y_ROW_STRIDE  = 11'd2;
  localparam int                Y_LINES_PER_ROW = 2;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/y_line_capture_if.sv
// rtl/y_line_capture_if.sv - head-of-queue output handshake of the Y line capture block
interface y_line_capture_if #(
  parameter int TAG_W  = y_pkg::TAG_W,
  parameter int LINE_W = y_pkg::LINE_W
);
  import y_pkg::*;

  logic              ylc_outValid;
  logic              ylc_outReady;
  logic [TAG_W-1:0]  ylc_outTag;
  logic [LINE_W-1:0] ylc_outLine1;
  logic [LINE_W-1:0] ylc_outLine2;

  modport master (
    output ylc_outValid,
    output ylc_outTag,
    output ylc_outLine1,
    output ylc_outLine2,
    input  ylc_outReady
  );

  modport slave (
    input  ylc_outValid,
    input  ylc_outTag,
    input  ylc_outLine1,
    input  ylc_outLine2,
    output ylc_outReady
  );

endinterface

// File: rtl/y_pair_fifo.sv
// rtl/y_pair_fifo.sv - power-of-two FIFO of line-pair entries with occupancy count
module y_pair_fifo
  import y_pkg::*;
#(
  parameter int WIDTH = 528,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;
  fifo_op_e         op;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO is allowed when the head leaves on the same edge
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (op)
        FIFO_PUSH: count_q <= count_q + 1'b1;
        FIFO_POP:  count_q <= count_q - 1'b1;
        default:   count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/y_line_capture.sv
// rtl/y_line_capture.sv - pairs a captured row tag with next-cycle dual-port memory lines and queues them
module y_line_capture
  import y_pkg::*;
#(
  parameter int LINE_W = y_pkg::LINE_W,
  parameter int TAG_W  = y_pkg::TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ylc_enable,
  input  logic                   ylc_capture,
  input  logic [TAG_W-1:0]       ylc_rowNum,
  input  logic [LINE_W-1:0]      ylc_memData1,
  input  logic [LINE_W-1:0]      ylc_memData2,
  y_line_capture_if.master       ylc_out,
  output logic [$clog2(DEPTH):0] ylc_count,
  output logic                   ylc_overflow
);

  localparam int ENTRY_W = TAG_W + 2 * LINE_W;

  logic               pend_valid;
  logic [TAG_W-1:0]   pend_tag;
  logic               flush;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               drop;
  logic               overflow_q;
  logic [ENTRY_W-1:0] head;

  assign flush = !ylc_enable;
  assign pop   = !empty && ylc_out.ylc_outReady;
  assign push  = ylc_enable && pend_valid && (!full || pop);
  assign drop  = ylc_enable && pend_valid && full && !pop;

  // The decoder flags the capture one cycle before the memory data shows up
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= ylc_capture;
    end
  end

  always_ff @(posedge clock) begin
    if (ylc_capture) begin
      pend_tag <= ylc_rowNum;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  y_pair_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({pend_tag, ylc_memData1, ylc_memData2}),
    .pop       (pop),
    .pop_data  (head),
    .count     (ylc_count),
    .full      (full),
    .empty     (empty)
  );

  assign ylc_out.ylc_outValid = !empty;
  assign ylc_out.ylc_outTag   = head[ENTRY_W-1 -: TAG_W];
  assign ylc_out.ylc_outLine1 = head[2*LINE_W-1 -: LINE_W];
  assign ylc_out.ylc_outLine2 = head[LINE_W-1:0];
  assign ylc_overflow         = overflow_q;

endmodule
